// File: rtl/sap_alu_pkg.sv
// Shared types and helpers for the SAP ALU serial add/subtract datapath.
package sap_alu_pkg;

  localparam int unsigned SLICE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: both addends share a sign that the sum does not.
  function automatic logic signed_overflow(input logic a_msb, input logic b_msb,
                                           input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// SLICE_W-bit generate/propagate carry-lookahead adder, purely combinational.
module cla_slice #(
  parameter int unsigned SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is expanded as a flat sum of products over g/p and cin.
  always_comb begin
    logic w_t;
    logic w_u;
    w_c    = '0;
    w_c[0] = cin;
    w_t    = 1'b0;
    w_u    = 1'b0;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      w_t = cin;
      for (int j = 0; j <= i; j++) w_t = w_t & w_p[j];
      for (int j = 0; j <= i; j++) begin
        w_u = w_g[j];
        for (int k = j + 1; k <= i; k++) w_u = w_u & w_p[k];
        w_t = w_t | w_u;
      end
      w_c[i+1] = w_t;
    end
  end

  assign sum  = w_p ^ w_c[SLICE_W-1:0];
  assign cout = w_c[SLICE_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Slice-serial WIDTH-bit add/subtract with start/done handshake and registered flags.
// Define ADDER_SINGLE_CYCLE_EN to ripple NSLICES slices and finish in one RUN cycle.
module nibble_serial_addsub
  import sap_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SLICE_W = SLICE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int unsigned NSLICES = WIDTH / SLICE_W;
  localparam int unsigned MSB     = WIDTH - 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;

  logic [WIDTH-1:0] w_next_result;
  logic             w_next_carry;
  logic             w_last;

`ifdef ADDER_SINGLE_CYCLE_EN
  logic [NSLICES:0] w_chain;

  assign w_chain[0] = r_carry;

  for (genvar gi = 0; gi < int'(NSLICES); gi++) begin : g_slice
    cla_slice #(.SLICE_W(SLICE_W)) u_slice (
      .a    (r_a[gi*SLICE_W +: SLICE_W]),
      .b    (r_b[gi*SLICE_W +: SLICE_W]),
      .cin  (w_chain[gi]),
      .sum  (w_next_result[gi*SLICE_W +: SLICE_W]),
      .cout (w_chain[gi+1])
    );
  end

  assign w_next_carry = w_chain[NSLICES];
  assign w_last       = 1'b1;
`else
  localparam int unsigned IDX_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  logic [IDX_W-1:0]   r_idx;
  logic [SLICE_W-1:0] w_sum;
  logic               w_slice_cout;

  cla_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (r_a[r_idx*SLICE_W +: SLICE_W]),
    .b    (r_b[r_idx*SLICE_W +: SLICE_W]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_slice_cout)
  );

  // Only the current slice of the result changes each RUN cycle.
  always_comb begin
    w_next_result = result;
    w_next_result[r_idx*SLICE_W +: SLICE_W] = w_sum;
  end

  assign w_next_carry = w_slice_cout;
  assign w_last       = (r_idx == IDX_W'(NSLICES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
`ifndef ADDER_SINGLE_CYCLE_EN
      r_idx    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract as a + ~b + ~borrow so one adder serves both operations.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            busy    <= 1'b1;
            r_state <= RUN;
`ifndef ADDER_SINGLE_CYCLE_EN
            r_idx   <= '0;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          result  <= w_next_result;
          r_carry <= w_next_carry;
`ifndef ADDER_SINGLE_CYCLE_EN
          r_idx   <= r_idx + 1'b1;
`endif
          if (w_last) begin
            r_state  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cout     <= w_next_carry;
            zero     <= (w_next_result == '0);
            negative <= w_next_result[MSB];
            overflow <= signed_overflow(r_a[MSB], r_b[MSB], w_next_result[MSB]);
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub: 8-bit and 16-bit instances on one clock.
module tb_nibble_serial_addsub;

`ifdef ADDER_SINGLE_CYCLE_EN
  localparam int LAT8  = 2;
  localparam int LAT16 = 2;
`else
  localparam int LAT8  = 3;
  localparam int LAT16 = 5;
`endif

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start8, sub8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, zero8, neg8, ovf8;
  logic [7:0]  result8;
  logic        start16, sub16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, zero16, neg16, ovf16;
  logic [15:0] result16;

  int n_tests = 0;
  int n_fail  = 0;
  int push_cnt8 = 0, done_cnt8 = 0, push_cnt16 = 0, done_cnt16 = 0;
  logic prev_done8 = 1'b0, prev_done16 = 1'b0;
  exp_t q8[$];
  exp_t q16[$];

  nibble_serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .zero(zero8),
    .negative(neg8), .overflow(ovf8)
  );

  nibble_serial_addsub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .result(result16), .cout(cout16), .zero(zero16),
    .negative(neg16), .overflow(ovf16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] r, input logic co, input logic z,
                              input logic n, input logic v);
    exp_t e;
    e.res = r; e.co = co; e.z = z; e.n = n; e.v = v;
    return e;
  endfunction

  // Reference: a + (sub ? ~b : b) + (sub ? ~cin : cin) at width w.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic ci, input int w);
    exp_t        e;
    logic [16:0] full;
    logic [15:0] mask, bb;
    logic        c;
    mask  = 16'((17'd1 << w) - 17'd1);
    bb    = (s ? ~b : b) & mask;
    c     = s ? ~ci : ci;
    full  = {1'b0, a & mask} + {1'b0, bb} + 17'(c);
    e.res = full[15:0] & mask;
    e.co  = full[w];
    e.z   = (e.res == 16'd0);
    e.n   = e.res[w-1];
    e.v   = (a[w-1] == bb[w-1]) && (e.res[w-1] != a[w-1]);
    return e;
  endfunction

  // Output monitors: pop the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      done_cnt8++;
      check("pulse8", 32'(prev_done8), 32'd0);
      if (q8.size() == 0) check("spurious_done8", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("result8", 32'(result8), 32'(e.res[7:0]));
        check("cout8", 32'(cout8), 32'(e.co));
        check("zero8", 32'(zero8), 32'(e.z));
        check("neg8", 32'(neg8), 32'(e.n));
        check("ovf8", 32'(ovf8), 32'(e.v));
      end
    end
    prev_done8 = done8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done16) begin
      done_cnt16++;
      check("pulse16", 32'(prev_done16), 32'd0);
      if (q16.size() == 0) check("spurious_done16", 32'd1, 32'd0);
      else begin
        e = q16.pop_front();
        check("result16", 32'(result16), 32'(e.res));
        check("cout16", 32'(cout16), 32'(e.co));
        check("zero16", 32'(zero16), 32'(e.z));
        check("neg16", 32'(neg16), 32'(e.n));
        check("ovf16", 32'(ovf16), 32'(e.v));
      end
    end
    prev_done16 = done16;
  end

  task automatic push8(input exp_t e);
    q8.push_back(e);
    push_cnt8++;
  endtask

  // One 8-bit operation; edges counted include the accepting edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic ci, input exp_t e);
    int edges, busyc;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; cin8 = ci; start8 = 1'b1;
    push8(e);
    edges = 0; busyc = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) busyc++;
    end while (!done8 && edges < 20);
    check("lat8", 32'(edges), 32'(LAT8));
    check("busy8", 32'(busyc), 32'(LAT8 - 1));
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic ci, input exp_t e);
    int edges;
    @(negedge clk);
    a16 = a; b16 = b; sub16 = s; cin16 = ci; start16 = 1'b1;
    q16.push_back(e);
    push_cnt16++;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start16 = 1'b0;
    end while (!done16 && edges < 40);
    check("lat16", 32'(edges), 32'(LAT16));
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    logic        rs, rc;

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(result8), 32'd0);
    check("rst_flags", 32'({cout8, zero8, neg8, ovf8}), 32'd0);
    rst = 1'b0;

    // Directed cases
    op8(8'h3C, 8'h45, 1'b0, 1'b0, mk(16'h81, 1'b0, 1'b0, 1'b1, 1'b1));
    op8(8'hFF, 8'h01, 1'b0, 1'b0, mk(16'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    op8(8'h0F, 8'h00, 1'b0, 1'b1, mk(16'h10, 1'b0, 1'b0, 1'b0, 1'b0));
    op8(8'h10, 8'h20, 1'b1, 1'b0, mk(16'hF0, 1'b0, 1'b0, 1'b1, 1'b0));
    op8(8'h80, 8'h01, 1'b1, 1'b0, mk(16'h7F, 1'b1, 1'b0, 1'b0, 1'b1));

    // Start held high: back-to-back operations
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    push8(mk(16'h03, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01;
    push8(mk(16'h80, 1'b0, 1'b0, 1'b1, 1'b1));
    repeat (LAT8) @(posedge clk);
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h05; sub8 = 1'b1;
    push8(mk(16'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    repeat (LAT8) @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; sub8 = 1'b0;
    repeat (LAT8 + 2) @(negedge clk);
    check("b2b_drained", 32'(q8.size()), 32'd0);

    // Start pulse while busy is ignored
    @(negedge clk);
    a8 = 8'h22; b8 = 8'h33; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
    push8(mk(16'h55, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h99; b8 = 8'h99;
    check("busy_after_accept", 32'(busy8), 32'd1);
    if (LAT8 > 2) begin
      @(posedge clk);
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (LAT8 + 3) @(negedge clk);
    check("ignored_drained", 32'(q8.size()), 32'd0);

    // Reset during the first RUN cycle aborts the operation
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_result", 32'(result8), 32'd0);
    check("abort_flags", 32'({cout8, zero8, neg8, ovf8}), 32'd0);
    repeat (LAT8 + 2) @(negedge clk);
    op8(8'h01, 8'h01, 1'b0, 1'b0, mk(16'h02, 1'b0, 1'b0, 1'b0, 1'b0));

    // Random 8-bit operations
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      op8(ra, rb, rs, rc, model(16'(ra), 16'(rb), rs, rc, 8));
    end

    // 16-bit instance
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0));
    op16(16'h8000, 16'h0001, 1'b1, 1'b0, mk(16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      wa = 16'($urandom_range(0, 65535));
      wb = 16'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      op16(wa, wb, rs, rc, model(wa, wb, rs, rc, 16));
    end

    repeat (6) @(negedge clk);
    check("q8_empty", 32'(q8.size()), 32'd0);
    check("q16_empty", 32'(q16.size()), 32'd0);
    check("dones8", 32'(done_cnt8), 32'(push_cnt8));
    check("dones16", 32'(done_cnt16), 32'(push_cnt16));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Parametrised successor to the 4-bit quad-adder slice.
- Computes WIDTH-bit add or subtract by time-multiplexing one SLICE_W-bit carry-lookahead slice, least-significant slice first.
- Carry is held in a register between cycles, the way cascaded 283s are chained in hardware.
- Sits behind the SAP ALU control word; start/done handshake with the controller; result and flags registered.

Parameters:
- WIDTH, 8: operand/result width; must be a multiple of SLICE_W and at least SLICE_W.
- SLICE_W, 4: bits processed per cycle.
- NSLICES = WIDTH/SLICE_W: derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request an operation; sampled only when not busy.
- sub  in  1  0 = a+b+cin; 1 = a-b-cin.
- a  in  WIDTH  operand A, captured on the accepted start.
- b  in  WIDTH  operand B, captured on the accepted start.
- cin  in  1  carry-in when sub=0, borrow-in when sub=1.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  WIDTH  registered sum/difference.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- overflow  out  1  signed overflow.

Behaviour:
- Clocking: single clock domain, clk; rst is synchronous and active-high, sampled on the rising edge.
- Reset: state=IDLE; busy, done, result, cout, zero, negative and overflow all 0; internal operand/carry registers and slice index cleared.
- States:
  - IDLE: start=1 → latch a; latch b'=sub?~b:b; latch carry=sub?~cin:cin; idx=0; go RUN.
  - RUN: each cycle add slice idx of a and b' plus carry; write result slice idx; update carry; idx++. After slice NSLICES-1 go DONE.
  - DONE: done=1 for exactly one cycle; flags updated this cycle. start=1 here is accepted exactly as in IDLE and goes to RUN; otherwise go IDLE.
- Latency: done is high in the cycle beginning NSLICES+1 rising edges after the edge that accepted start. Throughput is one operation per NSLICES+1 cycles.
- busy=1 in RUN only; start while busy is ignored (not queued).
- Outputs hold their last values until the next accepted start. result slices update progressively during RUN and are not valid until done.
- Flags:
  - cout = final carry.
  - zero = (result==0).
  - negative = MSB of result.
  - overflow = (a[MSB]==b'[MSB]) && (result[MSB]!=a[MSB]).
- Operands changing after acceptance have no effect.
- rst during RUN or DONE aborts the operation; next cycle state and outputs are as on reset, and no done pulse is produced.
- WIDTH==SLICE_W is legal: one RUN cycle.

Optional Feature:
- ADDER_SINGLE_CYCLE_EN defined:
  - Full-width add in one RUN cycle via a combinational ripple of NSLICES slices.
  - done follows 2 edges after the start edge regardless of WIDTH.
  - Flags, handshake and reset behaviour unchanged.
- Not defined: serial behaviour above; exactly one slice instance in hardware.

Decomposition:
- Package sap_alu_pkg:
  - state enum {IDLE, RUN, DONE}.
  - SLICE_W default constant.
  - helper function computing signed overflow.
- Sub-module cla_slice: SLICE_W-bit generate/propagate lookahead adder (a, b, cin → sum, cout), combinational. It is instantiated once, or NSLICES times under ADDER_SINGLE_CYCLE_EN.

Test Plan (WIDTH=8 unless noted):
- 0x3C+0x45, sub=0, cin=0 → result 0x81, cout 0, overflow 1, negative 1, zero 0; done exactly 3 edges after start; busy high 2 cycles.
- 0xFF+0x01, cin=0 → result 0x00, cout 1, zero 1, overflow 0; then 0x0F+0x00 with cin=1 → 0x10, carry crosses the slice boundary.
- sub=1: 0x10-0x20, cin=0 → 0xF0, cout 0 (borrow), negative 1; 0x80-0x01 → 0x7F, cout 1, overflow 1.
- Start held high continuously → back-to-back operations one per 3 cycles. A start pulse while busy is ignored: result reflects the first operands, and only one done pulse per accepted start.
- rst asserted during the first RUN cycle → next cycle all outputs 0, state IDLE, no done; a subsequent 0x01+0x01 → 0x02.
- WIDTH=16: 0xFFFF+0x0001 → 0x0000, cout 1, zero 1, done 5 edges after start. With ADDER_SINGLE_CYCLE_EN the same case has done 2 edges after start.
